// File: rtl/bram_uart_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM states and frame constants.
package bram_uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_e;

    localparam logic [7:0]  LDR_MAGIC          = 8'hA5;
    localparam int unsigned LDR_BYTE_W         = 8;
    localparam int unsigned LDR_BYTES_PER_WORD = 4;

endpackage

// File: rtl/bram_uart_loader_word_assembler.sv
// Packs received bytes little-endian into words, keeps the running XOR and
// raises a one-cycle write request the cycle after a word completes.
module loader_word_assembler
    import bram_uart_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  wr_pend_o,
    output logic [7:0]            xor_o
);

    localparam int unsigned SHIFT_W = DATA_WIDTH - LDR_BYTE_W;

    logic [1:0]            idx_q, idx_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  pend_q, pend_d;
    logic [7:0]            xor_q, xor_d;

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        word_d  = word_q;
        pend_d  = 1'b0;
        xor_d   = xor_q;
        if (byte_valid_i) begin
            idx_d   = idx_q + 2'd1;
            shift_d = {byte_i, shift_q[SHIFT_W-1:LDR_BYTE_W]};
            xor_d   = xor_q ^ byte_i;
            // Final byte lands on top of the three already shifted in
            if (idx_q == 2'(LDR_BYTES_PER_WORD - 1)) begin
                word_d = {byte_i, shift_q};
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            idx_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            pend_q  <= 1'b0;
            xor_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            pend_q  <= pend_d;
            xor_q   <= xor_d;
        end
    end

    assign word_o    = word_q;
    assign wr_pend_o = pend_q;
    assign xor_o     = xor_q;

endmodule

// File: rtl/bram_uart_loader.sv
// UART boot loader: parses MAGIC/LEN/data/CHK frames into BRAM while holding
// the CPU in reset, then hands the BRAM port to the CPU after a good checksum.
module bram_uart_loader
    import bram_uart_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_WORDS      = 8192,
    parameter logic [7:0]  MAGIC          = LDR_MAGIC,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  cpu_ena,
    input  logic                  cpu_wea,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic                  bram_ena,
    output logic                  bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH-1:0] words_loaded
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    loader_state_e         state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] words_q, words_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [15:0]           len_hdr;
    logic                  active, last_write, asm_valid, wr_pend;
    logic [DATA_WIDTH-1:0] asm_word;
    logic [7:0]            run_xor;

    assign len_hdr    = {rx_data, len_lo_q};
    assign active     = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK};
    assign last_write = wr_pend && (words_q == len_q - 1'b1);
    // A byte coinciding with the final write strobe is the checksum, not data
    assign asm_valid  = rx_valid && (state_q == ST_DATA) && !last_write;

    loader_word_assembler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (state_q == ST_IDLE),
        .byte_valid_i (asm_valid),
        .byte_i       (rx_data),
        .word_o       (asm_word),
        .wr_pend_o    (wr_pend),
        .xor_o        (run_xor)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        words_d  = words_q;
        cnt_d    = '0;
        if (active) cnt_d = rx_valid ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE:   if (rx_valid && rx_data == MAGIC) state_d = ST_LEN_LO;
            ST_LEN_LO: if (rx_valid) begin
                len_lo_d = rx_data;
                state_d  = ST_LEN_HI;
            end
            ST_LEN_HI: if (rx_valid) begin
                if (len_hdr > 16'(MAX_WORDS))  state_d = ST_ERROR;
                else if (len_hdr == 16'd0)     state_d = ST_CHECK;
                else begin
                    len_d   = len_hdr[ADDR_WIDTH-1:0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: if (wr_pend) begin
                words_d = words_q + 1'b1;
                if (last_write) begin
                    if (rx_valid) state_d = (rx_data == run_xor) ? ST_DONE : ST_ERROR;
                    else          state_d = ST_CHECK;
                end
            end
            ST_CHECK:  if (rx_valid) state_d = (rx_data == run_xor) ? ST_DONE : ST_ERROR;
            default:   state_d = state_q;
        endcase

        if (active && !rx_valid && cnt_q == CNT_LAST) state_d = ST_ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            words_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            words_q  <= words_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        bram_ena  = 1'b0;
        bram_wea  = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        if (state_q == ST_DONE) begin
            bram_ena  = cpu_ena;
            bram_wea  = cpu_wea;
            bram_addr = cpu_addr;
            bram_din  = cpu_din;
        end else if (state_q == ST_DATA && wr_pend) begin
            bram_ena  = 1'b1;
            bram_wea  = 1'b1;
            bram_addr = words_q;
            bram_din  = asm_word;
        end
    end

    assign cpu_hold     = (state_q != ST_DONE);
    assign load_done    = (state_q == ST_DONE);
    assign load_error   = (state_q == ST_ERROR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_bram_uart_loader.sv
// Self-checking bench for bram_uart_loader: directed and random frames against
// a frame-level reference model, plus timeout, passthrough and reset cases.
module tb_bram_uart_loader;

    localparam logic [7:0] MAGIC = 8'hA5;
    localparam int         TO    = 100;

    typedef logic [7:0]  bq_t [$];
    typedef logic [46:0] wq_t [$];

    logic        clk = 1'b0;
    logic        reset, rx_valid;
    logic [7:0]  rx_data;
    logic        cpu_ena, cpu_wea;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_din;
    logic        bram_ena, bram_wea;
    logic [13:0] bram_addr;
    logic [31:0] bram_din;
    logic        cpu_hold, load_done, load_error;
    logic [13:0] words_loaded;

    int          errors = 0;
    int          checks = 0;
    wq_t         act_writes;
    logic [31:0] mem [0:8191];
    bq_t         good_frame;

    bram_uart_loader #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .cpu_ena(cpu_ena), .cpu_wea(cpu_wea), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addr(bram_addr), .bram_din(bram_din),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // BRAM model and loader-side write monitor
    always @(posedge clk) if (bram_ena && bram_wea) mem[bram_addr[12:0]] <= bram_din;
    always @(negedge clk) if (bram_wea && cpu_hold) act_writes.push_back({bram_ena, bram_addr, bram_din});

    // Frame-level reference: expected writes {ena,addr,data} and final status
    function automatic void ref_model(input bq_t b, output wq_t w, output bit done, output bit err);
        int unsigned i = 0;
        int unsigned len;
        logic [7:0]  x = 8'h00;
        w = {}; done = 1'b0; err = 1'b0;
        while (i < b.size() && b[i] != MAGIC) i++;
        if (i + 3 > b.size()) return;
        len = int'(b[i+1]) + 256 * int'(b[i+2]);
        i += 3;
        if (len > 8192) begin err = 1'b1; return; end
        for (int unsigned k = 0; k < len; k++) begin
            if (i + 4 > b.size()) return;
            w.push_back({1'b1, 14'(k), b[i+3], b[i+2], b[i+1], b[i]});
            x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
            i += 4;
        end
        if (i >= b.size()) return;
        if (b[i] == x) done = 1'b1; else err = 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        act_writes.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic play(input bq_t b, input int maxgap);
        foreach (b[i]) send_byte(b[i], int'($urandom_range(0, maxgap)));
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        cpu_ena = 1'b1; cpu_wea = 1'b1; cpu_addr = 14'h1234; cpu_din = 32'h89ABCDEF;
        do_reset();
        checks++; if (cpu_hold !== 1'b1)      begin errors++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
        checks++; if (load_done !== 1'b0)     begin errors++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
        checks++; if (load_error !== 1'b0)    begin errors++; $display("FAIL reset_load_error got=%b exp=0", load_error); end
        checks++; if (words_loaded !== 14'd0) begin errors++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
        checks++;
        if ({bram_ena, bram_wea, bram_addr, bram_din} !== 48'd0) begin
            errors++;
            $display("FAIL reset_bram_outputs got=%b/%b/%h/%h exp=all zero", bram_ena, bram_wea, bram_addr, bram_din);
        end
    endtask

    task automatic test_directed_frames();
        for (int t = 0; t < 4; t++) begin
            bq_t b; wq_t ew; bit ed, ee;
            case (t)
                0: b = good_frame;
                1: begin b = good_frame; b[b.size()-1] = 8'h2B; end
                2: b = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
                default: b = '{8'hA5, 8'h00, 8'h00, 8'h00};
            endcase
            do_reset();
            play(b, t);
            ref_model(b, ew, ed, ee);
            checks++;
            if (act_writes.size() != ew.size()) begin
                errors++; $display("FAIL dir%0d_write_count got=%0d exp=%0d", t, act_writes.size(), ew.size());
            end
            foreach (ew[i]) if (i < act_writes.size()) begin
                checks++;
                if (act_writes[i] !== ew[i]) begin errors++; $display("FAIL dir%0d_write%0d got=%h exp=%h", t, i, act_writes[i], ew[i]); end
            end
            checks++; if (load_done !== ed)  begin errors++; $display("FAIL dir%0d_done got=%b exp=%b", t, load_done, ed); end
            checks++; if (load_error !== ee) begin errors++; $display("FAIL dir%0d_error got=%b exp=%b", t, load_error, ee); end
            checks++; if (cpu_hold !== !ed)  begin errors++; $display("FAIL dir%0d_hold got=%b exp=%b", t, cpu_hold, !ed); end
            checks++;
            if (words_loaded !== 14'(ew.size())) begin
                errors++; $display("FAIL dir%0d_words got=%0d exp=%0d", t, words_loaded, ew.size());
            end
            if (t == 0) begin
                checks++; if (mem[0] !== 32'h12345678) begin errors++; $display("FAIL dir0_mem0 got=%h exp=12345678", mem[0]); end
                checks++; if (mem[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL dir0_mem1 got=%h exp=deadbeef", mem[1]); end
            end
        end
    endtask

    task automatic test_len_limits();
        bq_t b;
        int  strobes;
        do_reset();
        b = '{8'hA5, 8'h01, 8'h20};
        play(b, 1);
        checks++; if (load_error !== 1'b1)    begin errors++; $display("FAIL len8193_error got=%b exp=1", load_error); end
        checks++; if (act_writes.size() != 0) begin errors++; $display("FAIL len8193_writes got=%0d exp=0", act_writes.size()); end
        checks++; if (cpu_hold !== 1'b1)      begin errors++; $display("FAIL len8193_hold got=%b exp=1", cpu_hold); end
        // Largest legal length must be accepted and start writing
        do_reset();
        b = '{8'hA5, 8'h00, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        play(b, 0);
        strobes = act_writes.size();
        checks++; if (load_error !== 1'b0)    begin errors++; $display("FAIL len8192_error got=%b exp=0", load_error); end
        checks++; if (words_loaded !== 14'd2) begin errors++; $display("FAIL len8192_words got=%0d exp=2", words_loaded); end
        checks++;
        if (strobes != 2 || act_writes[strobes-1] !== {1'b1, 14'd1, 32'h08070605}) begin
            errors++; $display("FAIL len8192_writes got_count=%0d exp_count=2 exp_last=%h", strobes, {1'b1, 14'd1, 32'h08070605});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        repeat (TO - 1) @(negedge clk);
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0 after %0d cycles", load_error, TO - 1); end
        @(negedge clk);
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL timeout_fire got=%b exp=1 after %0d cycles", load_error, TO); end
        checks++; if (cpu_hold !== 1'b1)   begin errors++; $display("FAIL timeout_hold got=%b exp=1", cpu_hold); end
    endtask

    task automatic test_cpu_passthrough();
        do_reset();
        play(good_frame, 2);
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL pass_done got=%b exp=1", load_done); end
        cpu_ena = 1'b1; cpu_wea = 1'b1; cpu_addr = 14'd5; cpu_din = 32'hCAFEF00D;
        #1;
        checks++;
        if ({bram_ena, bram_wea, bram_addr, bram_din} !== {1'b1, 1'b1, 14'd5, 32'hCAFEF00D}) begin
            errors++; $display("FAIL pass_mux got=%b/%b/%h/%h exp=1/1/0005/cafef00d", bram_ena, bram_wea, bram_addr, bram_din);
        end
        @(posedge clk); #1;
        checks++; if (mem[5] !== 32'hCAFEF00D) begin errors++; $display("FAIL pass_mem5 got=%h exp=cafef00d", mem[5]); end
        cpu_wea = 1'b0; cpu_addr = 14'h2ABC;
        #1;
        checks++;
        if (bram_wea !== 1'b0 || bram_addr !== 14'h2ABC) begin
            errors++; $display("FAIL pass_read got=%b/%h exp=0/2abc", bram_wea, bram_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_data();
        do_reset();
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h44, 0); send_byte(8'h33, 0); send_byte(8'h22, 0); send_byte(8'h11, 0);
        checks++; if (bram_wea !== 1'b1) begin errors++; $display("FAIL mid_strobe got=%b exp=1", bram_wea); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bram_ena, bram_wea, bram_addr, bram_din} !== 48'd0 || words_loaded !== 14'd0 ||
            {cpu_hold, load_done, load_error} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset got=%b/%b/%h/%h words=%0d hold/done/err=%b exp=zeros words=0 hold/done/err=100",
                     bram_ena, bram_wea, bram_addr, bram_din, words_loaded, {cpu_hold, load_done, load_error});
        end
        reset = 1'b0;
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 10; n++) begin
            bq_t b; wq_t ew; bit ed, ee;
            int unsigned len;
            logic [7:0] j, x;
            b = {}; x = 8'h00;
            repeat ($urandom_range(0, 2)) begin
                j = 8'($urandom_range(0, 255));
                if (j == MAGIC) j = 8'h00;
                b.push_back(j);
            end
            len = (n == 0) ? 0 : $urandom_range(1, 5);
            b.push_back(MAGIC); b.push_back(8'(len)); b.push_back(8'h00);
            repeat (len * 4) begin j = 8'($urandom); b.push_back(j); x ^= j; end
            if ($urandom_range(0, 2) == 0) x ^= 8'($urandom_range(1, 255));
            b.push_back(x);
            cpu_ena = 1'($urandom); cpu_wea = 1'($urandom); cpu_addr = 14'($urandom); cpu_din = $urandom;
            do_reset();
            play(b, n % 3);
            ref_model(b, ew, ed, ee);
            checks++;
            if (act_writes.size() != ew.size()) begin
                errors++; $display("FAIL rand%0d_write_count got=%0d exp=%0d", n, act_writes.size(), ew.size());
            end
            foreach (ew[i]) if (i < act_writes.size()) begin
                checks++;
                if (act_writes[i] !== ew[i]) begin errors++; $display("FAIL rand%0d_write%0d got=%h exp=%h", n, i, act_writes[i], ew[i]); end
            end
            checks++; if (load_done !== ed)  begin errors++; $display("FAIL rand%0d_done got=%b exp=%b", n, load_done, ed); end
            checks++; if (load_error !== ee) begin errors++; $display("FAIL rand%0d_error got=%b exp=%b", n, load_error, ee); end
            checks++;
            if (words_loaded !== 14'(ew.size())) begin
                errors++; $display("FAIL rand%0d_words got=%0d exp=%0d", n, words_loaded, ew.size());
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_ena = 1'b0; cpu_wea = 1'b0; cpu_addr = '0; cpu_din = '0;
        good_frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                       8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        test_reset();
        test_directed_frames();
        test_len_limits();
        test_timeout();
        test_cpu_passthrough();
        test_reset_mid_data();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
